// File: rtl/seq_term_server_if.sv
// Request/response bundle between requesters, the response consumer and the
// recurrence term server.
interface seq_term_server_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_ovf;

  // requesters plus response consumer
  modport master (
    output req_valid, req_index, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );

  // term server
  modport slave (
    input  req_valid, req_index, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
  );
endinterface

// File: rtl/seq_term_server.sv
// Round-robin shared server for the recurrence t(n)=t(n-2)+t(n-3), seeds 0,1,1.
// A granted request loads the 3-register core, steps it n times, and returns
// r0 = t(n) mod 2^WIDTH with an exact overflow flag.
//
// state | meaning
// IDLE  | arbitrating, grant offered to first valid requester from rr pointer
// RUN   | stepping the core, counter holds remaining steps
// RESP  | response presented, waiting for rsp_ready
module seq_term_server #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic             busy,
  seq_term_server_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  job_id;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] r0, r1, r2;
  logic             o0, o1, o2;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_ovf_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic [IDX_W-1:0]   sel_index;
  logic [ID_W-1:0]    next_ptr;
  logic [WIDTH:0]     sum;
  int                 idx;

  // Round-robin search starting at rr_ptr; only offered in IDLE without clear.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    found     = 1'b0;
    sel_index = '0;
    idx       = 0;
    if (state == IDLE && !clear) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          found    = 1'b1;
          grant_id = ID_W'(idx);
        end
      end
    end
    if (found) begin
      grant[grant_id] = 1'b1;
      sel_index       = bus.req_index[grant_id*IDX_W +: IDX_W];
    end
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  // extra bit catches the carry out of the step addition
  assign sum      = {1'b0, r0} + {1'b0, r1};

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

  // Sequencer, arbitration pointer, recurrence core and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      job_id     <= '0;
      cnt        <= '0;
      r0         <= '0;
      r1         <= WIDTH'(1);
      r2         <= WIDTH'(1);
      o0         <= 1'b0;
      o1         <= 1'b0;
      o2         <= 1'b0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else if (clear) begin
      // abort leaves pointer and core contents as they are
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            job_id <= grant_id;
            cnt    <= sel_index;
            r0     <= '0;
            r1     <= WIDTH'(1);
            r2     <= WIDTH'(1);
            o0     <= 1'b0;
            o1     <= 1'b0;
            o2     <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            r0  <= r1;
            r1  <= r2;
            r2  <= sum[WIDTH-1:0];
            o0  <= o1;
            o1  <= o2;
            o2  <= sum[WIDTH] | o0 | o1;
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data_q <= r0;
            rsp_ovf_q  <= o0;
            rsp_id_q   <= job_id;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_term_server.sv
// Bench for seq_term_server with two requesters and an 8-bit term width so
// that overflow is reachable.
module tb_seq_term_server;
  localparam int NR = 2;
  localparam int W  = 8;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic busy;

  int tests    = 0;
  int failures = 0;
  int exp_ptr  = 0;

  always #5 clk = ~clk;

  seq_term_server_if #(.NUM_REQ(NR), .WIDTH(W), .IDX_W(IW)) bus ();

  seq_term_server #(.NUM_REQ(NR), .WIDTH(W), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  // Reference: exact term value (saturated far above 2^W) plus a mod-2^W track.
  function automatic logic [8:0] model(int n);
    longint a = 0, b = 1, c = 1, nx;
    int ma = 0, mb = 1, mc = 1, mn;
    logic [8:0] res;
    for (int i = 0; i < n; i++) begin
      nx = a + b;
      if (nx > 64'd1000000) nx = 64'd1000000;
      a = b; b = c; c = nx;
      mn = (ma + mb) % 256;
      ma = mb; mb = mc; mc = mn;
    end
    res = {(a >= 256), ma[7:0]};
    return res;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request from a single requester, optional backpressure, then handshake.
  task automatic run_job(int id, int n, int hold, int exp_data, int exp_ovf, string tag);
    int cyc;
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_index[id*IW +: IW] = IW'(n);
    bus.rsp_ready = 1'b0;
    #1;
    check({tag, "_grant"}, bus.req_ready, 1 << id);
    @(posedge clk); #1;
    bus.req_valid = '0;
    exp_ptr = (id + 1) % NR;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, n + 1);
    bus.req_valid = '1;
    for (int h = 0; h < hold; h++) begin
      #1;
      check({tag, "_hold_valid"}, bus.rsp_valid, 1);
      check({tag, "_hold_data"}, bus.rsp_data, exp_data);
      check({tag, "_hold_id"}, bus.rsp_id, id);
      check({tag, "_hold_nogrant"}, bus.req_ready, 0);
      check({tag, "_hold_busy"}, busy, 1);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_ovf"}, bus.rsp_ovf, exp_ovf);
    check({tag, "_id"}, bus.rsp_id, id);
    check({tag, "_nogrant"}, bus.req_ready, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    check({tag, "_done_valid"}, bus.rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    int cyc, got, expg, exp_id, id, n, hold, seen;
    logic [8:0] m;

    reset = 1'b1;
    clear = 1'b0;
    bus.req_valid = '0;
    bus.req_index = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_ovf", bus.rsp_ovf, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // directed terms
    run_job(0, 10, 0, 9, 0, "n10");
    run_job(1, 0, 0, 0, 0, "n0");
    run_job(1, 1, 0, 1, 0, "n1");
    run_job(1, 2, 0, 1, 0, "n2");
    run_job(1, 3, 0, 1, 0, "n3");
    run_job(0, 21, 0, 200, 0, "n21");
    run_job(1, 22, 0, 9, 1, "n22");
    run_job(0, 6, 5, 3, 0, "stall");

    // both requesters held valid: grants alternate from the pointer
    @(negedge clk);
    bus.req_index = {IW'(5), IW'(5)};
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    expg = exp_ptr;
    exp_id = 0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 200) begin
      #1;
      if (bus.req_ready != '0) begin
        check("alt_grant", bus.req_ready, 1 << expg);
        exp_id = expg;
        expg = (expg + 1) % NR;
      end
      if (bus.rsp_valid) begin
        check("alt_id", bus.rsp_id, exp_id);
        check("alt_data", bus.rsp_data, 2);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    exp_ptr = expg;
    check("alt_count", got, 4);

    // clear during RUN of n=20
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_index[0 +: IW] = IW'(20);
    @(posedge clk); #1;
    bus.req_valid = '0;
    exp_ptr = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    check("clr_nogrant", bus.req_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    bus.req_valid = '0;
    check("clr_busy", busy, 0);
    check("clr_valid", bus.rsp_valid, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    check("clr_no_rsp", seen, 0);
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    check("clr_ptr_kept", bus.req_ready, 1 << exp_ptr);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    run_job(1, 4, 0, 2, 0, "after_clr");

    // clear wins over a same-cycle response handshake
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_index[0 +: IW] = IW'(1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    exp_ptr = 1;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("clr_resp_reached", bus.rsp_valid, 1);
    @(negedge clk);
    clear = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.rsp_ready = 1'b0;
    check("clr_resp_valid", bus.rsp_valid, 0);
    check("clr_resp_busy", busy, 0);

    // reset mid-run restores the pointer to requester 0
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_index[0 +: IW] = IW'(30);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    bus.req_valid = '1;
    #1;
    check("mid_rst_ptr", bus.req_ready, 1);
    bus.req_valid = '0;

    // randomized jobs against the reference
    for (int t = 0; t < 25; t++) begin
      id = $urandom_range(0, NR - 1);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 40);
      hold = $urandom_range(0, 3);
      m = model(n);
      run_job(id, n, hold, m[7:0], m[8], "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
